// File: rtl/psum_accumulator.sv
// Temporal partial-sum accumulator: sums len consecutive products from the multiplier
// switch and queues each dot-product result in a show-ahead FIFO for the reduction network.
module psum_accumulator #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int CNT_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             i_cfg_valid,
    input  logic [CNT_WIDTH-1:0]             i_vec_len,
    input  logic                             i_valid,
    input  logic [OUT_DATA_TYPE-1:0]         i_data,
    input  logic                             i_ready,
    output logic                             o_valid,
    output logic [OUT_DATA_TYPE-1:0]         o_data,
    output logic [$clog2(FIFO_DEPTH):0]      o_count,
    output logic                             o_busy,
    output logic                             o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                   state, state_next;
    logic [CNT_WIDTH-1:0]     len;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [OUT_DATA_TYPE-1:0] acc;

    logic [OUT_DATA_TYPE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic                     cfg_load;
    logic                     accept;
    logic                     last;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     push_ok;
    logic [OUT_DATA_TYPE-1:0] sum;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A config in the same cycle as a product takes priority and the product is discarded.
    always_comb begin
        state_next = state;
        cfg_load   = i_cfg_valid && (i_vec_len != '0);
        accept     = (state == ACCUM) && i_valid && !cfg_load;
        last       = (cnt == len - CNT_WIDTH'(1));
        sum        = (cnt == '0) ? i_data : acc + i_data;
        push       = accept && last;
        pop        = o_valid && i_ready;
        full       = (count == CNT_W'(FIFO_DEPTH));
        push_ok    = push && (!full || pop);
        if (cfg_load) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            len <= '0;
            cnt <= '0;
            acc <= '0;
        end else if (cfg_load) begin
            len <= i_vec_len;
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (last) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
                acc <= sum;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= sum;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (push && !push_ok) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = o_valid ? mem[rd_ptr] : '0;
    assign o_count = count;
    assign o_busy  = (cnt != '0);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-vector bench for psum_accumulator: accumulation, wrap, FIFO full/overflow,
// config priority, and asynchronous reset.
module tb_psum_accumulator;

    logic        CLK;
    logic        rst;
    logic        i_cfg_valid;
    logic [7:0]  i_vec_len;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [2:0]  o_count;
    logic        o_busy;
    logic        o_overflow;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    psum_accumulator #(
        .OUT_DATA_TYPE(32),
        .CNT_WIDTH    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .i_cfg_valid(i_cfg_valid),
        .i_vec_len  (i_vec_len),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        i_cfg_valid = 1'b0;
        i_vec_len   = '0;
        i_valid     = 1'b0;
        i_data      = '0;
    endtask

    task automatic configure(input logic [7:0] len);
        i_cfg_valid = 1'b1;
        i_vec_len   = len;
        i_valid     = 1'b0;
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic product(input logic [31:0] d);
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        i_ready = 1'b0;
        #12;
        vectors++;
        if ({o_valid, o_data, o_count, o_busy, o_overflow} !== 38'd0)
            begin errors++; $display("FAIL reset_state: got v=%b d=%h c=%0d b=%b o=%b, expected all 0",
                o_valid, o_data, o_count, o_busy, o_overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        i_ready = 1'b1;
        configure(8'd4);
        product(32'd1);
        vectors++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy1: got %b, expected 1", o_busy); end
        product(32'd2);
        product(32'd3);
        vectors++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0)
            begin errors++; $display("FAIL basic_busy3: got busy=%b valid=%b, expected 1 0", o_busy, o_valid); end
        product(32'd4);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'd10 || o_busy !== 1'b0)
            begin errors++; $display("FAIL basic_result: got v=%b d=%0d b=%b, expected 1 10 0", o_valid, o_data, o_busy); end
        step();
        vectors++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got valid=%b, expected 0", o_valid); end
    endtask

    task automatic test_gap_wrap();
        i_ready = 1'b1;
        configure(8'd3);
        product(32'd5);
        step();
        step();
        product(32'hFFFF_FFFE);
        vectors++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0)
            begin errors++; $display("FAIL gap_hold: got busy=%b valid=%b, expected 1 0", o_busy, o_valid); end
        product(32'd7);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'd10)
            begin errors++; $display("FAIL gap_result: got v=%b d=%0d, expected 1 10", o_valid, o_data); end
        product(32'h7FFF_FFFF);
        product(32'd1);
        product(32'd0);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'h8000_0000 || o_overflow !== 1'b0)
            begin errors++; $display("FAIL wrap_result: got v=%b d=%h ovf=%b, expected 1 80000000 0",
                o_valid, o_data, o_overflow); end
        step();
    endtask

    task automatic test_overflow();
        i_ready = 1'b0;
        configure(8'd1);
        for (int k = 1; k <= 4; k++) product(32'(k));
        vectors++;
        if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_data !== 32'd1)
            begin errors++; $display("FAIL ovf_fill: got c=%0d ovf=%b d=%0d, expected 4 0 1", o_count, o_overflow, o_data); end
        product(32'd5);
        vectors++;
        if (o_count !== 3'd4 || o_overflow !== 1'b1)
            begin errors++; $display("FAIL ovf_drop: got c=%0d ovf=%b, expected 4 1", o_count, o_overflow); end
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_data !== 32'(k))
                begin errors++; $display("FAIL ovf_drain%0d: got v=%b d=%0d, expected 1 %0d", k, o_valid, o_data, k); end
            step();
        end
        vectors++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_overflow !== 1'b1)
            begin errors++; $display("FAIL ovf_empty: got v=%b c=%0d ovf=%b, expected 0 0 1", o_valid, o_count, o_overflow); end
    endtask

    task automatic test_full_push_pop();
        pulse_reset();
        i_ready = 1'b0;
        configure(8'd1);
        for (int k = 1; k <= 4; k++) product(32'(10 + k));
        i_ready = 1'b1;
        product(32'd15);
        vectors++;
        if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_data !== 32'd12)
            begin errors++; $display("FAIL full_pushpop: got c=%0d ovf=%b d=%0d, expected 4 0 12", o_count, o_overflow, o_data); end
        for (int k = 2; k <= 5; k++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_data !== 32'(10 + k))
                begin errors++; $display("FAIL full_drain%0d: got v=%b d=%0d, expected 1 %0d", k, o_valid, o_data, 10 + k); end
            step();
        end
        vectors++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got valid=%b, expected 0", o_valid); end
    endtask

    task automatic test_cfg_priority();
        i_ready = 1'b1;
        configure(8'd4);
        product(32'd3);
        product(32'd3);
        i_cfg_valid = 1'b1;
        i_vec_len   = 8'd2;
        i_valid     = 1'b1;
        i_data      = 32'd9;
        step();
        idle_inputs();
        vectors++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0)
            begin errors++; $display("FAIL cfg_drop: got busy=%b valid=%b, expected 0 0", o_busy, o_valid); end
        product(32'd1);
        vectors++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL cfg_first: got busy=%b, expected 1", o_busy); end
        product(32'd1);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'd2)
            begin errors++; $display("FAIL cfg_result: got v=%b d=%0d, expected 1 2", o_valid, o_data); end
        step();
        configure(8'd0);
        product(32'd4);
        product(32'd5);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'd9)
            begin errors++; $display("FAIL cfg_len0_ignored: got v=%b d=%0d, expected 1 9", o_valid, o_data); end
        step();
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0;
        configure(8'd1);
        product(32'd21);
        product(32'd22);
        configure(8'd3);
        product(32'd8);
        vectors++;
        if (o_count !== 3'd2 || o_busy !== 1'b1)
            begin errors++; $display("FAIL arst_setup: got c=%0d busy=%b, expected 2 1", o_count, o_busy); end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL arst_immediate: got v=%b c=%0d b=%b, expected 0 0 0", o_valid, o_count, o_busy); end
        #1;
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) product(32'd7);
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_count !== 3'd0)
            begin errors++; $display("FAIL arst_idle: got v=%b b=%b c=%0d, expected 0 0 0", o_valid, o_busy, o_count); end
        configure(8'd1);
        product(32'd6);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 32'd6)
            begin errors++; $display("FAIL arst_reconfig: got v=%b d=%0d, expected 1 6", o_valid, o_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap_wrap();
        test_overflow();
        test_full_push_pop();
        test_cfg_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
